// File: rtl/beat_clock_pkg.sv
// ---------------------------------------------------------------------------
// beat_clock_pkg - shared widths, constants and FSM states for beat_clock
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package beat_clock_pkg;

  localparam int LOW_W              = 10;
  localparam int CROTCHET_W         = 7;
  localparam int TICKS_PER_CROTCHET = 1024;
  localparam int QUAVER_TICK        = 512;
  localparam int PRESCALE_W         = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } beat_state_e;

endpackage

`default_nettype wire

// File: rtl/beat_prescaler.sv
// ---------------------------------------------------------------------------
// beat_prescaler - 16-bit clock divider with enable/clear; one-cycle tick out
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module beat_prescaler
  import beat_clock_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_en,
  input  logic                  i_clr,
  input  logic [PRESCALE_W-1:0] i_div,
  output logic                  o_tick
);

  logic [PRESCALE_W-1:0] r_cnt;
  logic                  w_term;

  // >= rather than == so a divisor that shrinks mid-count still terminates
  assign w_term = (r_cnt >= (i_div - PRESCALE_W'(1)));
  assign o_tick = i_en && !i_clr && w_term;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_term ? '0 : (r_cnt + PRESCALE_W'(1));
    end
  end

endmodule

`default_nettype wire

// File: rtl/beat_clock.sv
// ---------------------------------------------------------------------------
// beat_clock - song timebase: tick phase, crotchet index and beat strobes
// Rev 1.0. Option: BEAT_CLOCK_SWING_EN lengthens first-quaver ticks.
// ---------------------------------------------------------------------------
`default_nettype none

module beat_clock
  import beat_clock_pkg::*;
#(
  parameter int CLK_DIV     = 19409,
  parameter int SONG_LEN    = 128,
  parameter int SWING_DELTA = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic                  loop_en,
  input  logic                  restart,
  output logic [LOW_W-1:0]      low_count,
  output logic [CROTCHET_W-1:0] crotchet,
  output logic                  crotchet_pulse,
  output logic                  quaver_pulse,
  output logic                  playing,
  output logic                  done
);

  localparam logic [LOW_W-1:0]      c_low_max   = LOW_W'(TICKS_PER_CROTCHET - 1);
  localparam logic [LOW_W-1:0]      c_quaver    = LOW_W'(QUAVER_TICK);
  localparam logic [LOW_W-1:0]      c_quaver_m1 = LOW_W'(QUAVER_TICK - 1);
  localparam logic [CROTCHET_W-1:0] c_last      = CROTCHET_W'(SONG_LEN - 1);

  if ((CLK_DIV < 2) || (CLK_DIV > 65535)) begin : g_bad_clk_div
    $error("beat_clock: CLK_DIV out of range");
  end
  if ((SONG_LEN < 2) || (SONG_LEN > 128)) begin : g_bad_song_len
    $error("beat_clock: SONG_LEN out of range");
  end
  if ((SWING_DELTA < 0) || (SWING_DELTA >= CLK_DIV - 1)) begin : g_bad_swing
    $error("beat_clock: SWING_DELTA out of range");
  end

  beat_state_e           r_state;
  beat_state_e           w_state_nxt;
  logic [LOW_W-1:0]      r_low;
  logic [LOW_W-1:0]      w_low_nxt;
  logic [CROTCHET_W-1:0] r_crot;
  logic [CROTCHET_W-1:0] w_crot_nxt;
  logic                  r_cpulse;
  logic                  w_cpulse_nxt;
  logic                  r_qpulse;
  logic                  w_qpulse_nxt;
  logic                  r_playing;
  logic                  r_done;
  logic                  w_pre_en;
  logic                  w_pre_clr;
  logic                  w_tick;
  logic [PRESCALE_W-1:0] w_div;

`ifdef BEAT_CLOCK_SWING_EN
  // Long ticks in the first quaver, short in the second: crotchet length is unchanged
  assign w_div = (r_low < c_quaver) ? PRESCALE_W'(CLK_DIV + SWING_DELTA)
                                    : PRESCALE_W'(CLK_DIV - SWING_DELTA);
`else
  assign w_div = PRESCALE_W'(CLK_DIV);
`endif

  assign w_pre_en  = (r_state == ST_PLAY);
  assign w_pre_clr = restart;

  beat_prescaler u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_pre_en),
    .i_clr  (w_pre_clr),
    .i_div  (w_div),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_low_nxt    = r_low;
    w_crot_nxt   = r_crot;
    w_cpulse_nxt = 1'b0;
    w_qpulse_nxt = 1'b0;

    if (restart) begin
      w_low_nxt  = '0;
      w_crot_nxt = '0;
      if (run) begin
        w_state_nxt  = ST_PLAY;
        w_cpulse_nxt = 1'b1;
        w_qpulse_nxt = 1'b1;
      end else begin
        w_state_nxt = ST_IDLE;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (run) begin
            w_state_nxt  = ST_PLAY;
            w_cpulse_nxt = 1'b1;
            w_qpulse_nxt = 1'b1;
          end
        end
        ST_PLAY: begin
          if (!run) begin
            w_state_nxt = ST_PAUSE;
          end
          // A tick on the pause edge is still applied so no clocks are lost
          if (w_tick) begin
            if (r_low == c_low_max) begin
              if (r_crot != c_last) begin
                w_low_nxt    = '0;
                w_crot_nxt   = r_crot + CROTCHET_W'(1);
                w_cpulse_nxt = 1'b1;
                w_qpulse_nxt = 1'b1;
              end else if (loop_en) begin
                w_low_nxt    = '0;
                w_crot_nxt   = '0;
                w_cpulse_nxt = 1'b1;
                w_qpulse_nxt = 1'b1;
              end else begin
                w_state_nxt = ST_DONE;
              end
            end else begin
              w_low_nxt    = r_low + LOW_W'(1);
              w_qpulse_nxt = (r_low == c_quaver_m1);
            end
          end
        end
        ST_PAUSE: begin
          if (run) begin
            w_state_nxt = ST_PLAY;
          end
        end
        default: begin
          w_state_nxt = r_state;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_low     <= '0;
      r_crot    <= '0;
      r_cpulse  <= 1'b0;
      r_qpulse  <= 1'b0;
      r_playing <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_low     <= w_low_nxt;
      r_crot    <= w_crot_nxt;
      r_cpulse  <= w_cpulse_nxt;
      r_qpulse  <= w_qpulse_nxt;
      r_playing <= (w_state_nxt == ST_PLAY);
      r_done    <= (w_state_nxt == ST_DONE);
    end
  end

  assign low_count      = r_low;
  assign crotchet       = r_crot;
  assign crotchet_pulse = r_cpulse;
  assign quaver_pulse   = r_qpulse;
  assign playing        = r_playing;
  assign done           = r_done;

endmodule

`default_nettype wire

// File: tb/tb_beat_clock.sv
// ---------------------------------------------------------------------------
// tb_beat_clock - self-checking bench for beat_clock (CLK_DIV=4, SONG_LEN=4)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_beat_clock;

  localparam int CLK_DIV  = 4;
  localparam int SONG_LEN = 4;
`ifdef BEAT_CLOCK_SWING_EN
  localparam int SD = 1;
`else
  localparam int SD = 0;
`endif
  localparam int PER  = 1024 * CLK_DIV;
  localparam int QG   = 512 * (CLK_DIV + SD);
  localparam int TLEN = CLK_DIV + SD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       loop_en = 1'b0;
  logic       restart = 1'b0;
  logic [9:0] low_count;
  logic [6:0] crotchet;
  logic       crotchet_pulse;
  logic       quaver_pulse;
  logic       playing;
  logic       done;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t_mark = 0;

  typedef struct {
    int         cyc;
    logic       cp;
    logic [6:0] crot;
    logic [9:0] low;
  } ev_t;
  ev_t exp_q[$];

  beat_clock #(
    .CLK_DIV     (CLK_DIV),
    .SONG_LEN    (SONG_LEN),
    .SWING_DELTA (SD)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .run            (run),
    .loop_en        (loop_en),
    .restart        (restart),
    .low_count      (low_count),
    .crotchet       (crotchet),
    .crotchet_pulse (crotchet_pulse),
    .quaver_pulse   (quaver_pulse),
    .playing        (playing),
    .done           (done)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: run did not complete within time limit");
    $fatal(1, "watchdog");
  end

  // Every pulse must match the oldest expected event (cycle, kind, position).
  initial forever begin
    ev_t e;
    @(negedge clk);
    if (rst_n && (crotchet_pulse || quaver_pulse)) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse cyc=%0d cp=%0b qp=%0b crot=%0d low=%0d",
                 cyc, crotchet_pulse, quaver_pulse, crotchet, low_count);
      end else begin
        e = exp_q.pop_front();
        if ((cyc !== e.cyc) || (crotchet_pulse !== e.cp) || (quaver_pulse !== 1'b1) ||
            (crotchet !== e.crot) || (low_count !== e.low)) begin
          bad++;
          $display("FAIL pulse got cyc=%0d cp=%0b qp=%0b crot=%0d low=%0d want cyc=%0d cp=%0b qp=1 crot=%0d low=%0d",
                   cyc, crotchet_pulse, quaver_pulse, crotchet, low_count,
                   e.cyc, e.cp, e.crot, e.low);
        end
      end
    end
  end

  task automatic push_ev(input int c, input logic cp, input int cr, input int lo);
    ev_t e;
    e.cyc  = c;
    e.cp   = cp;
    e.crot = 7'(cr);
    e.low  = 10'(lo);
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    total++;
    if (low_count !== 10'd0) begin bad++; $display("FAIL reset_low got=%0d want=0", low_count); end
    total++;
    if (crotchet !== 7'd0) begin bad++; $display("FAIL reset_crot got=%0d want=0", crotchet); end
    total++;
    if ({crotchet_pulse, quaver_pulse} !== 2'b00) begin
      bad++; $display("FAIL reset_pulses got=%b want=00", {crotchet_pulse, quaver_pulse});
    end
    total++;
    if ({playing, done} !== 2'b00) begin
      bad++; $display("FAIL reset_status got=%b want=00", {playing, done});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Loop mode: five crotchets 0,1,2,3,0 with exact spacing.
  task automatic test_loop_play;
    int c0;
    c0 = cyc;
    loop_en = 1'b1;
    run = 1'b1;
    for (int k = 0; k < 5; k++) begin
      push_ev(c0 + 1 + k * PER, 1'b1, k % SONG_LEN, 0);
      if (k < 4) push_ev(c0 + 1 + k * PER + QG, 1'b0, k % SONG_LEN, 512);
    end
    wait_cyc(c0 + 1);
    total++;
    if ({playing, done} !== 2'b10) begin
      bad++; $display("FAIL start_status got=%b want=10", {playing, done});
    end
    wait_cyc(c0 + 1 + 4 * PER);
    total++;
    if (crotchet !== 7'd0) begin bad++; $display("FAIL loop_wrap_crot got=%0d want=0", crotchet); end
    t_mark = c0 + 1 + 4 * PER;
  endtask

  // 100-cycle pause mid-crotchet; the crotchet finishes 100 cycles late.
  task automatic test_pause;
    int s;
    s = t_mark;
    push_ev(s + QG + 100, 1'b0, 0, 512);
    push_ev(s + PER + 100, 1'b1, 1, 0);
    wait_cyc(s + 1000);
    run = 1'b0;
    wait_cyc(s + 1001);
    total++;
    if (low_count !== 10'(1001 / TLEN)) begin
      bad++; $display("FAIL pause_low got=%0d want=%0d", low_count, 1001 / TLEN);
    end
    total++;
    if (playing !== 1'b0) begin bad++; $display("FAIL pause_playing got=%0b want=0", playing); end
    wait_cyc(s + 1100);
    total++;
    if ((low_count !== 10'(1001 / TLEN)) || (crotchet !== 7'd0)) begin
      bad++; $display("FAIL pause_frozen got low=%0d crot=%0d want low=%0d crot=0",
                      low_count, crotchet, 1001 / TLEN);
    end
    run = 1'b1;
    wait_cyc(s + 1101);
    total++;
    if (playing !== 1'b1) begin bad++; $display("FAIL resume_playing got=%0b want=1", playing); end
    t_mark = s + PER + 100;
  endtask

  // No loop: crotchets 1..3 then DONE holding 1023/3 with no further pulses.
  task automatic test_done;
    int t;
    t = t_mark;
    loop_en = 1'b0;
    push_ev(t + QG, 1'b0, 1, 512);
    for (int k = 2; k < 4; k++) begin
      push_ev(t + (k - 1) * PER, 1'b1, k, 0);
      push_ev(t + (k - 1) * PER + QG, 1'b0, k, 512);
    end
    wait_cyc(t + 3 * PER - 1);
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL done_early got=%0b want=0", done); end
    wait_cyc(t + 3 * PER);
    total++;
    if ({playing, done} !== 2'b01) begin
      bad++; $display("FAIL done_status got=%b want=01", {playing, done});
    end
    total++;
    if ((low_count !== 10'd1023) || (crotchet !== 7'd3)) begin
      bad++; $display("FAIL done_hold got low=%0d crot=%0d want low=1023 crot=3", low_count, crotchet);
    end
    wait_cyc(t + 3 * PER + 5000);
    total++;
    if ((done !== 1'b1) || (low_count !== 10'd1023) || (crotchet !== 7'd3)) begin
      bad++; $display("FAIL done_stays got done=%0b low=%0d crot=%0d want done=1 low=1023 crot=3",
                      done, low_count, crotchet);
    end
    t_mark = cyc;
  endtask

  // Restart out of DONE, then a restart coincident with the song-end tick.
  task automatic test_restart;
    int d;
    int w;
    d = t_mark;
    restart = 1'b1;
    push_ev(d + 1, 1'b1, 0, 0);
    push_ev(d + 1 + QG, 1'b0, 0, 512);
    for (int k = 1; k < 4; k++) begin
      push_ev(d + 1 + k * PER, 1'b1, k, 0);
      push_ev(d + 1 + k * PER + QG, 1'b0, k, 512);
    end
    wait_cyc(d + 1);
    restart = 1'b0;
    total++;
    if ({playing, done, low_count, crotchet} !== {2'b10, 10'd0, 7'd0}) begin
      bad++; $display("FAIL restart_from_done got play=%0b done=%0b low=%0d crot=%0d want 1 0 0 0",
                      playing, done, low_count, crotchet);
    end
    w = d + 1 + 4 * PER;
    wait_cyc(w - 1);
    restart = 1'b1;
    push_ev(w, 1'b1, 0, 0);
    wait_cyc(w);
    restart = 1'b0;
    total++;
    if ({playing, done, low_count, crotchet} !== {2'b10, 10'd0, 7'd0}) begin
      bad++; $display("FAIL restart_at_end got play=%0b done=%0b low=%0d crot=%0d want 1 0 0 0",
                      playing, done, low_count, crotchet);
    end
    wait_cyc(w + 10);
    total++;
    if ((done !== 1'b0) || (low_count !== 10'(10 / TLEN))) begin
      bad++; $display("FAIL after_restart got done=%0b low=%0d want done=0 low=%0d",
                      done, low_count, 10 / TLEN);
    end
    run = 1'b0;
    wait_cyc(w + 20);
    restart = 1'b1;
    wait_cyc(w + 21);
    restart = 1'b0;
    total++;
    if ({playing, done, low_count, crotchet} !== {2'b00, 10'd0, 7'd0}) begin
      bad++; $display("FAIL restart_to_idle got play=%0b done=%0b low=%0d crot=%0d want 0 0 0 0",
                      playing, done, low_count, crotchet);
    end
    t_mark = cyc;
  endtask

  // Asynchronous reset in the middle of play clears everything at once.
  task automatic test_async_reset;
    int r;
    r = t_mark;
    run = 1'b1;
    push_ev(r + 1, 1'b1, 0, 0);
    wait_cyc(r + 300);
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if ({playing, done, crotchet_pulse, quaver_pulse, low_count, crotchet} !== 21'd0) begin
      bad++; $display("FAIL async_reset got play=%0b done=%0b low=%0d crot=%0d want all 0",
                      playing, done, low_count, crotchet);
    end
    @(negedge clk);
    run = 1'b0;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    total++;
    if ({playing, low_count} !== 11'd0) begin
      bad++; $display("FAIL post_reset_idle got play=%0b low=%0d want 0 0", playing, low_count);
    end
  endtask

  initial begin
    test_reset();
    test_loop_play();
    test_pause();
    test_done();
    test_restart();
    test_async_reset();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL missing_pulses got=%0d pending want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/beat_clock.md
# beat_clock

Song-position timebase for the PWM audio design. It divides the 39.75 MHz system clock into a 1024-tick-per-crotchet phase count (`low_count`) and a 7-bit crotchet index (`crotchet`), with single-cycle beat strobes. It sits upstream of the music (note/PWM) and display stages, which consume `low_count`, `crotchet` and `crotchet_pulse` as their common song clock. Run, pause, restart and loop are controlled from the top level.

## Interface
Parameters:
- `CLK_DIV`, 19409: system clocks per tick. 1024 ticks make one crotchet, about 120 BPM at 39.75 MHz. Legal range is 2 to 2^16-1.
- `SONG_LEN`, 128: number of crotchets in the song. Legal range is 2 to 128.
- `SWING_DELTA`, 0: tick-length skew in clocks, used only when swing is compiled in. Must satisfy `SWING_DELTA < CLK_DIV-1`.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `run`  in  1  level; 1 = play, 0 = pause.
- `loop_en`  in  1  level; 1 = wrap to crotchet 0 at song end.
- `restart`  in  1  single-cycle strobe; rewind to song start.
- `low_count`  out  10  tick phase within the current crotchet.
- `crotchet`  out  7  current crotchet index.
- `crotchet_pulse`  out  1  one-cycle strobe at each crotchet start.
- `quaver_pulse`  out  1  one-cycle strobe at each quaver start.
- `playing`  out  1  high in state PLAY.
- `done`  out  1  high in state DONE.

## Operation
States are IDLE, PLAY, PAUSE and DONE. Reset enters IDLE.
- **IDLE**
  - `run`=1 → PLAY.
  - Emit `crotchet_pulse` and `quaver_pulse` on the entry cycle, so downstream starts note 0.
- **PLAY**
  - The prescaler counts 0..`CLK_DIV`-1. Its terminal count is a tick.
  - Each tick increments `low_count`.
  - A tick at `low_count`=1023 does three things: `low_count` → 0, `crotchet` +1, `crotchet_pulse` asserted.
  - `run`=0 → PAUSE.
- **Song end:** a tick at `low_count`=1023 while `crotchet`=`SONG_LEN`-1:
  - With `loop_en`=1: `crotchet` → 0, `low_count` → 0, pulses asserted, stay in PLAY.
  - With `loop_en`=0: → DONE. `low_count` and `crotchet` hold at 1023 and `SONG_LEN`-1, no pulse.
- **PAUSE**
  - Prescaler, `low_count` and `crotchet` hold.
  - `run`=1 → PLAY and counting resumes from the held prescaler value.
  - No pulse is emitted on resume.
- **DONE**
  - Outputs hold.
  - Only `restart` leaves this state.
- **`restart`**, accepted in any state:
  - Prescaler, `low_count` and `crotchet` clear to 0.
  - Next state is PLAY if `run`=1, otherwise IDLE.
  - Entry to PLAY via `restart` emits both pulses.
  - `restart` beats a simultaneous tick, `run` change or song end.
- **`quaver_pulse`** asserts whenever `crotchet_pulse` does, and also on the tick where `low_count` becomes 512.
- **Arithmetic:**
  - `low_count` wraps naturally at 10 bits.
  - `crotchet` compares against `SONG_LEN`-1 and never exceeds it.
  - The prescaler is 16 bits.

## Timing
- All outputs are registered.
- Reset values: `low_count`=0, `crotchet`=0, `crotchet_pulse`=0, `quaver_pulse`=0, `playing`=0, `done`=0.
- Pulses are high for exactly one cycle: the same cycle the new `low_count`/`crotchet` values first appear.
- `run` rising in IDLE: PLAY, `playing`=1 and pulses appear on the next edge, a latency of 1 cycle.
- `restart` sampled at edge N gives cleared outputs after edge N.
- Crotchet period is exactly 1024×`CLK_DIV` clocks while in PLAY.
- Deasserting `rst_n` at any point returns to IDLE with reset values, with no residual pulse.

## Configuration
- **`BEAT_CLOCK_SWING_EN`**
  - When defined: ticks with `low_count` < 512 last `CLK_DIV`+`SWING_DELTA` clocks, and the remaining ticks last `CLK_DIV`-`SWING_DELTA`.
  - The crotchet period is unchanged. The second quaver starts late by 512×`SWING_DELTA` clocks.
  - When undefined: every tick is `CLK_DIV` clocks and `SWING_DELTA` is ignored.

## Structure
- Package `beat_clock_pkg` holds:
  - the state enum (IDLE/PLAY/PAUSE/DONE);
  - `LOW_W`=10, `CROTCHET_W`=7, `TICKS_PER_CROTCHET`=1024, `QUAVER_TICK`=512.
- Sub-module `beat_prescaler` holds:
  - the 16-bit divider with enable, clear and a divisor input;
  - a one-cycle `tick` output.
- The top holds the FSM and the position counters.

## Test plan
Bench parameters are `CLK_DIV`=4 and `SONG_LEN`=4.
- Reset, then `run`=1 → pulses one cycle after `run`. `crotchet_pulse` repeats every 4096 cycles. `quaver_pulse` also fires 2048 cycles after each `crotchet_pulse`.
- `loop_en`=1, run 5 crotchets → `crotchet` sequence 0,1,2,3,0 with a pulse at every step.
- `loop_en`=0 → after crotchet 3 completes: `done`=1, `low_count`=1023, `crotchet`=3, no further pulses.
- `run`=0 for 100 cycles mid-crotchet → outputs frozen. On resume the crotchet completes exactly 4096 PLAY cycles after it started.
- `restart` coincident with the crotchet-3 wrap in DONE-bound play → outputs 0, state PLAY, pulses asserted, `done` stays 0.
- Built with `BEAT_CLOCK_SWING_EN` and `SWING_DELTA`=1 → quaver gap is 2560 cycles then 1536 cycles; crotchet period stays 4096.
